// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state encoding and register-index width for the pipeline controller
package pipeline_ctrl_pkg;
  localparam int REG_W = 4;
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FAULT = 2'd2} state_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: flags an ID instruction that reads the destination of a load still in EXE
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] exe_dest,
  output logic             load_use
);
  assign load_use = id_valid && exe_mem_r_en && exe_wb_en &&
                    (id_src1 == exe_dest || (id_two_src && id_src2 == exe_dest));
endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: stall/flush control with memory-wait FSM, timeout fault and saturating perf counters
module pipeline_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             freeze_ifid,
  output logic             bubble_idexe,
  output logic             flush_ifid,
  output logic             freeze_all,
  output logic             mem_timeout,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  logic [1:0]    rst_sync;
  logic          rst_n, mem_stall, load_use, ld_stall;
  logic [WW-1:0] cnt;
  state_t        st;
  // Reset asserts asynchronously but releases two clocks after the pin deasserts
  always_ff @(posedge clk or negedge reset)
    if (!reset) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];
  hazard_detect u_hazard (
    .id_valid    (id_valid),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_two_src  (id_two_src),
    .exe_wb_en   (exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en),
    .exe_dest    (exe_dest),
    .load_use    (load_use)
  );
  // A freeze masks branch/load-use so they fire on the first unfrozen cycle
  assign mem_stall    = mem_req && !mem_ready;
  assign freeze_all   = rst_n && (st == FAULT || mem_stall);
  assign ld_stall     = rst_n && !freeze_all && load_use && !exe_branch_taken;
  assign flush_ifid   = rst_n && !freeze_all && exe_branch_taken;
  assign bubble_idexe = ld_stall || flush_ifid;
  assign freeze_pc    = ld_stall;
  assign freeze_ifid  = ld_stall;
  assign state        = st;
  // cnt holds the number of consecutive stall cycles seen so far; it is 0 whenever in RUN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st           <= RUN;
      cnt          <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (st != FAULT) begin
        if (!mem_stall) begin
          st  <= RUN;
          cnt <= '0;
        end else if (cnt == WW'(MEM_TIMEOUT - 1)) begin
          st          <= FAULT;
          mem_timeout <= 1'b1;
        end else begin
          st  <= MEM_WAIT;
          cnt <= cnt + 1'b1;
        end
      end
      if ((freeze_all || ld_stall) && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
      if (flush_ifid && !(&flush_count)) flush_count <= flush_count + 1'b1;
    end
endmodule
